// File: rtl/mem_bus_arbiter.sv
// Three-way arbiter (load/store, fetch, DMA) onto one memory with a fixed wait-state window.
// Optional DMA anti-starvation promotion: define MEM_ARB_STARVE_GUARD_EN.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int WAIT_CYC   = 2,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_load,
    output logic              mem_store,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait
        $error("mem_bus_arbiter: WAIT_CYC out of range 1..15");
    end
    if (STARVE_LIM < 1 || STARVE_LIM > 255) begin : g_bad_starve
        $error("mem_bus_arbiter: STARVE_LIM out of range 1..255");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYC - 1);

    // Requester vectors are one-hot: [0]=ls, [1]=fetch, [2]=dma.
    state_t            state_q, state_d;
    logic [2:0]        id_q, id_d;
    logic [2:0]        gnt_q, gnt_d;
    logic [2:0]        done_q, done_d;
    logic              we_q, we_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_load_q, mem_load_d;
    logic              mem_store_q, mem_store_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic [2:0]        sel;
    logic              dma_promote;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [7:0] dma_wait_q, dma_wait_d;

    assign dma_promote = (dma_wait_q == 8'(STARVE_LIM));

    // Counts only while DMA is waiting, not while its own access is in flight.
    always_comb begin
        dma_wait_d = dma_wait_q;
        if (gnt_q[2])
            dma_wait_d = 8'd0;
        else if (dma_req && !(state_q != S_IDLE && id_q[2]) && dma_wait_q < 8'(STARVE_LIM))
            dma_wait_d = dma_wait_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) dma_wait_q <= 8'd0;
        else     dma_wait_q <= dma_wait_d;
    end
`else
    assign dma_promote = 1'b0;
`endif

    always_comb begin
        sel = 3'b000;
        if (dma_promote && dma_req) sel = 3'b100;
        else if (ls_req)            sel = 3'b001;
        else if (fetch_req)         sel = 3'b010;
        else if (dma_req)           sel = 3'b100;
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_load_d  = mem_load_q;
        mem_store_d = mem_store_q;
        rdata_d     = rdata_q;
        gnt_d       = 3'b000;
        done_d      = 3'b000;
        case (state_q)
            S_IDLE: begin
                if (sel != 3'b000) begin
                    state_d = S_ACCESS;
                    id_d    = sel;
                    gnt_d   = sel;
                    cnt_d   = 4'd0;
                    case (sel)
                        3'b001: begin
                            we_d = ls_we;  mem_addr_d = ls_addr;  mem_wdata_d = ls_wdata;
                        end
                        3'b010: begin
                            we_d = 1'b0;   mem_addr_d = fetch_addr; mem_wdata_d = mem_wdata_q;
                        end
                        default: begin
                            we_d = dma_we; mem_addr_d = dma_addr; mem_wdata_d = dma_wdata;
                        end
                    endcase
                    mem_load_d  = ~we_d;
                    mem_store_d = we_d;
                end
            end
            S_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    mem_load_d  = 1'b0;
                    mem_store_d = 1'b0;
                    done_d      = id_q;
                    if (!we_q) rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            id_q        <= 3'b000;
            gnt_q       <= 3'b000;
            done_q      <= 3'b000;
            we_q        <= 1'b0;
            cnt_q       <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_load_q  <= 1'b0;
            mem_store_q <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_load_q  <= mem_load_d;
            mem_store_q <= mem_store_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign ls_gnt     = gnt_q[0];
    assign fetch_gnt  = gnt_q[1];
    assign dma_gnt    = gnt_q[2];
    assign ls_done    = done_q[0];
    assign fetch_done = done_q[1];
    assign dma_done   = done_q[2];
    assign rdata      = rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_load   = mem_load_q;
    assign mem_store  = mem_store_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (WAIT_CYC=2, STARVE_LIM=8).
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req, ls_req, ls_we, dma_req, dma_we;
    logic [15:0] fetch_addr, ls_addr, ls_wdata, dma_addr, dma_wdata, mem_rdata;
    logic        fetch_gnt, fetch_done, ls_gnt, ls_done, dma_gnt, dma_done;
    logic        mem_load, mem_store, busy;
    logic [15:0] rdata, mem_addr, mem_wdata;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_done(ls_done),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done),
        .rdata(rdata), .mem_addr(mem_addr), .mem_load(mem_load), .mem_store(mem_store),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fetch_req = 0; ls_req = 0; ls_we = 0; dma_req = 0; dma_we = 0;
        fetch_addr = 0; ls_addr = 0; ls_wdata = 0; dma_addr = 0; dma_wdata = 0; mem_rdata = 0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({busy, mem_load, mem_store, ls_gnt, fetch_gnt, dma_gnt, ls_done, fetch_done, dma_done} !== 9'b0) begin
            fails++; $display("FAIL reset_ctl: got %b want 0", {busy, mem_load, mem_store, ls_gnt, fetch_gnt, dma_gnt, ls_done, fetch_done, dma_done});
        end
        tests++;
        if ({rdata, mem_addr, mem_wdata} !== 48'h0) begin
            fails++; $display("FAIL reset_data: got %h want 0", {rdata, mem_addr, mem_wdata});
        end
    endtask

    task automatic test_fetch();
        mem_rdata = 16'hA5C3; fetch_addr = 16'h0010; fetch_req = 1'b1;
        tick();
        tests++;
        if ({fetch_gnt, mem_load, mem_store, busy} !== 4'b1101 || mem_addr !== 16'h0010) begin
            fails++; $display("FAIL fetch_c1: got gnt/ld/st/busy=%b addr=%h want 1101 0010", {fetch_gnt, mem_load, mem_store, busy}, mem_addr);
        end
        tick();
        tests++;
        if ({fetch_gnt, mem_load, fetch_done} !== 3'b010 || mem_addr !== 16'h0010) begin
            fails++; $display("FAIL fetch_c2: got gnt/ld/done=%b addr=%h want 010 0010", {fetch_gnt, mem_load, fetch_done}, mem_addr);
        end
        tick();
        tests++;
        if ({fetch_done, mem_load, busy} !== 3'b101 || rdata !== 16'hA5C3) begin
            fails++; $display("FAIL fetch_c3: got done/ld/busy=%b rdata=%h want 101 a5c3", {fetch_done, mem_load, busy}, rdata);
        end
        fetch_req = 1'b0;
        tick();
        tests++;
        if ({fetch_done, busy, fetch_gnt} !== 3'b000) begin
            fails++; $display("FAIL fetch_c4: got done/busy/gnt=%b want 000", {fetch_done, busy, fetch_gnt});
        end
    endtask

    task automatic test_store();
        mem_rdata = 16'hFFFF;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h8001; ls_wdata = 16'h1234;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) ls_wdata = 16'hDEAD;  // latched already; must not leak through
            tests++;
            if (c < 3) begin
                if ({mem_store, mem_load, ls_gnt} !== {2'b10, c == 1} || mem_wdata !== 16'h1234 || mem_addr !== 16'h8001) begin
                    fails++; $display("FAIL store_c%0d: got st/ld/gnt=%b wdata=%h addr=%h want 10%0d 1234 8001", c, {mem_store, mem_load, ls_gnt}, mem_wdata, mem_addr, c == 1);
                end
            end else begin
                if ({ls_done, mem_store, mem_load} !== 3'b100 || rdata !== 16'hA5C3) begin
                    fails++; $display("FAIL store_done: got done/st/ld=%b rdata=%h want 100 a5c3", {ls_done, mem_store, mem_load}, rdata);
                end
            end
        end
        ls_req = 1'b0; ls_we = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        mem_rdata = 16'h5A5A; fetch_addr = 16'h0040; fetch_req = 1'b1;
        tick(); tick();
        tests++;
        if (mem_load !== 1'b1) begin
            fails++; $display("FAIL rstmid_pre: got mem_load=%b want 1", mem_load);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({mem_load, mem_store, busy, fetch_done, fetch_gnt} !== 5'b0 || rdata !== 16'h0) begin
            fails++; $display("FAIL rstmid_abort: got ld/st/busy/done/gnt=%b rdata=%h want 00000 0000", {mem_load, mem_store, busy, fetch_done, fetch_gnt}, rdata);
        end
        tick();
        tests++;
        if (fetch_gnt !== 1'b1 || mem_addr !== 16'h0040) begin
            fails++; $display("FAIL rstmid_regnt: got gnt=%b addr=%h want 1 0040", fetch_gnt, mem_addr);
        end
        tick(); tick();
        tests++;
        if (fetch_done !== 1'b1 || rdata !== 16'h5A5A) begin
            fails++; $display("FAIL rstmid_done: got done=%b rdata=%h want 1 5a5a", fetch_done, rdata);
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp_g, exp_d;
        do_reset();
        mem_rdata = 16'h0BAD;
        ls_addr = 16'h0100; fetch_addr = 16'h0200; dma_addr = 16'h0300;
        ls_req = 1; fetch_req = 1; dma_req = 1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_g = (c == 1) ? 3'b100 : (c == 5) ? 3'b010 : (c == 9) ? 3'b001 : 3'b000;
            exp_d = (c == 3) ? 3'b100 : (c == 7) ? 3'b010 : (c == 11) ? 3'b001 : 3'b000;
            tests++;
            if ({ls_gnt, fetch_gnt, dma_gnt} !== exp_g) begin
                fails++; $display("FAIL sim_gnt c%0d: got ls/fe/dma=%b want %b", c, {ls_gnt, fetch_gnt, dma_gnt}, exp_g);
            end
            tests++;
            if ({ls_done, fetch_done, dma_done} !== exp_d) begin
                fails++; $display("FAIL sim_done c%0d: got ls/fe/dma=%b want %b", c, {ls_done, fetch_done, dma_done}, exp_d);
            end
            if (mem_load && mem_store) begin
                tests++; fails++; $display("FAIL sim_strobes c%0d: load and store both high", c);
            end
            if (c == 5) begin
                tests++;
                if (mem_addr !== 16'h0200) begin
                    fails++; $display("FAIL sim_addr c5: got %h want 0200", mem_addr);
                end
            end
            if (ls_done)    ls_req = 0;
            if (fetch_done) fetch_req = 0;
            if (dma_done)   dma_req = 0;
        end
        tests++;
        if (rdata !== 16'h0BAD) begin
            fails++; $display("FAIL sim_rdata: got %h want 0bad", rdata);
        end
    endtask

    task automatic test_back_to_back();
        fetch_addr = 16'h0020; mem_rdata = 16'h1357; fetch_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            tests++;
            if ({fetch_gnt, fetch_done} !== {c == 1 || c == 5, c == 3 || c == 7}) begin
                fails++; $display("FAIL b2b c%0d: got gnt/done=%b want %b%b", c, {fetch_gnt, fetch_done}, c == 1 || c == 5, c == 3 || c == 7);
            end
            if (c == 4) begin
                tests++;
                if (busy !== 1'b0) begin
                    fails++; $display("FAIL b2b_idle: got busy=%b want 0", busy);
                end
            end
            if (c == 7) fetch_req = 1'b0;
        end
    endtask

    task automatic test_starve();
        int first_dma;
        do_reset();
        first_dma = -1;
        ls_addr = 16'h0111; dma_addr = 16'h0333;
        ls_req = 1'b1; dma_req = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (dma_gnt && first_dma < 0) first_dma = c;
            if (ls_gnt && dma_gnt) begin
                tests++; fails++; $display("FAIL starve_excl c%0d: two grants high", c);
            end
            if (dma_done) dma_req = 1'b0;
        end
        tests++;
`ifdef MEM_ARB_STARVE_GUARD_EN
        if (first_dma !== 9) begin
            fails++; $display("FAIL starve_promote: got first dma_gnt cycle %0d want 9", first_dma);
        end
`else
        if (first_dma !== -1) begin
            fails++; $display("FAIL starve_fixed: got dma_gnt at cycle %0d want none", first_dma);
        end
`endif
        ls_req = 1'b0; dma_req = 1'b0;
        repeat (6) tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL starve_drain: got busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_reset_mid_access();
        test_simultaneous();
        test_back_to_back();
        test_starve();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single unified memory between three requesters: instruction fetch (PC path), CPU load/store, and an external DMA port.
- Sequences each access through a fixed wait-state window sized to the memory access time, then returns a one-cycle completion pulse.
- Sits between the mainboard control logic and the memory block. It replaces the direct PC/load-store address mux with a registered, arbitrated bus.

Parameters:
- ADDR_W, 16: address width.
- DATA_W, 16: data width.
- WAIT_CYC, 2: clock cycles the memory strobe is held per access. Legal range 1..15.
- STARVE_LIM, 8: DMA wait cycles before DMA is promoted to top priority. Legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request, held until fetch_done.
- fetch_addr  in  ADDR_W  fetch address.
- fetch_gnt  out  1  one-cycle pulse: fetch accepted.
- fetch_done  out  1  one-cycle pulse: rdata valid for fetch.
- ls_req  in  1  load/store request.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_gnt  out  1  accept pulse.
- ls_done  out  1  completion pulse.
- dma_req  in  1  DMA request.
- dma_we  in  1  DMA write.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_gnt  out  1  accept pulse.
- dma_done  out  1  completion pulse.
- rdata  out  DATA_W  read data, shared by all requesters.
- mem_addr  out  ADDR_W  registered memory address.
- mem_load  out  1  memory read strobe.
- mem_store  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. All outputs go to 0, state goes to IDLE, the wait counter and DMA starvation counter clear, and rdata clears to 0.
- Reset mid-access aborts the access: strobes drop on the next edge and no done pulse is issued.
- States:
  - IDLE: arbitrate the sampled requests. If any request is present, latch that requester's addr/we/wdata and the requester id, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: mem_addr and mem_wdata are driven from the latched values. mem_load = ~we and mem_store = we. The counter counts 0..WAIT_CYC-1. On the last count, rdata <= mem_rdata (loads only; stores leave rdata unchanged), then go to DONE.
  - DONE: strobes are 0 and the id's done output is 1 for exactly this cycle. Always returns to IDLE. No arbitration in DONE.
- gnt: the id's gnt pulses in the first ACCESS cycle only.
- Latency: request sampled in IDLE at cycle 0 gives gnt at cycle 1 and done at cycle 1+WAIT_CYC. Minimum back-to-back spacing is WAIT_CYC+2 cycles.
- Priority: ls > fetch > dma, fixed, subject to the Optional Feature.
- Requester rules:
  - Holds req, addr, and wdata stable until its done pulse.
  - Must drop req on the edge after done. A req still high in the following IDLE is treated as a new request.
- Simultaneous requests: only the winner is granted. Losers stay pending, with no gnt and no lost request.
- Only one of the three gnt outputs and one of the three done outputs is ever high in a given cycle. mem_load and mem_store are never high together.
- Inputs changing during ACCESS have no effect, because address, data and direction are latched.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - An 8-bit dma_wait counter increments each cycle dma_req=1 while DMA is not the granted requester, saturating at STARVE_LIM.
  - If dma_wait==STARVE_LIM when in IDLE, DMA wins over ls and fetch.
  - dma_wait clears on dma_gnt and on rst.
- Undefined: strict fixed priority; DMA may starve indefinitely. No counter logic is present.

Test Plan:
- Fetch alone, WAIT_CYC=2: fetch_req=1, addr 0x0010, mem_rdata=0xA5C3 -> fetch_gnt at cycle 1; mem_load high at cycles 1-2 with mem_addr=0x0010; fetch_done and rdata=0xA5C3 at cycle 3.
- Store: ls_req=1, ls_we=1, addr 0x8001, wdata 0x1234 -> mem_store=1 for 2 cycles; mem_wdata=0x1234; mem_load=0 throughout; ls_done at cycle 3; rdata unchanged.
- ls, fetch and dma requesting in the same cycle -> grant order ls, fetch, dma; done pulses at cycles 3, 7, 11; never two gnts at once.
- Reset in the second ACCESS cycle of a fetch -> next cycle: strobes 0, busy 0, rdata 0, no fetch_done. Fetch re-requested afterwards completes normally.
- With MEM_ARB_STARVE_GUARD_EN and STARVE_LIM=8: ls_req held continuously plus dma_req -> dma_gnt issued at the first IDLE after dma_wait reaches 8, ahead of ls. Without the macro, dma_gnt never occurs while ls_req=1.
- Requester keeps req high one cycle past done -> treated as a second access: a second gnt follows at done+2.
